// File: rtl/scanout_pkg.sv
// Shared timing defaults and helpers for the tiled frame-buffer scan-out path.
package scanout_pkg;

  localparam int DEF_H_ACT  = 576;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 56;
  localparam int DEF_H_BP   = 72;
  localparam int DEF_V_ACT  = 432;
  localparam int DEF_V_FP   = 3;
  localparam int DEF_V_SYNC = 4;
  localparam int DEF_V_BP   = 11;

  // Pin level for a sync pulse; pol=1 means the pulse is driven high.
  function automatic logic sync_level(input logic active, input logic pol);
    sync_level = pol ? active : ~active;
  endfunction

  // Pixel index inside a tile word: row-major, rows of 2**tw_log2 pixels.
  function automatic int unsigned pix_index(input int unsigned off_x,
                                            input int unsigned off_y,
                                            input int unsigned tw_log2);
    pix_index = (off_y << tw_log2) + off_x;
  endfunction

endpackage

// File: rtl/scanout_timing.sv
// Free-running H/V raster counters with sync decode and frame-boundary strobes.
module scanout_timing
  import scanout_pkg::*;
#(
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int HW     = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
  parameter int VW     = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] cnt_h,
  output logic [VW-1:0] cnt_v,
  output logic          active,
  output logic          hs_on,
  output logic          vs_on,
  output logic          frame_first,
  output logic          frame_last
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  logic [31:0] h32;
  logic [31:0] v32;
  logic        h_wrap;
  logic        v_wrap;

  assign h32    = 32'(cnt_h);
  assign v32    = 32'(cnt_v);
  assign h_wrap = (h32 == H_TOT - 1);
  assign v_wrap = (v32 == V_TOT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (h_wrap) begin
      cnt_h <= '0;
      cnt_v <= v_wrap ? '0 : cnt_v + VW'(1);
    end else begin
      cnt_h <= cnt_h + HW'(1);
    end
  end

  assign active      = (h32 < H_ACT) && (v32 < V_ACT);
  assign hs_on       = (h32 >= H_ACT + H_FP) && (h32 < H_ACT + H_FP + H_SYNC);
  assign vs_on       = (v32 >= V_ACT + V_FP) && (v32 < V_ACT + V_FP + V_SYNC);
  assign frame_first = (h32 == 0) && (v32 == 0);
  // Scroll registers load here so a whole frame sees one scroll value.
  assign frame_last  = h_wrap && v_wrap;

endmodule

// File: rtl/tile_scanout.sv
// Tiled frame-buffer scan-out: scroll latch, tile addressing, 3-stage pixel pipeline.
// Define TILE_SCANOUT_BORDER_EN to paint active pixels outside the tile area with border_rgb.
module tile_scanout
  import scanout_pkg::*;
#(
  parameter int CH_BITS  = 4,
  parameter int TW_LOG2  = 3,
  parameter int TH_LOG2  = 3,
  parameter int TILES_X  = 72,
  parameter int TILES_Y  = 54,
  parameter int XB       = 7,
  parameter int YB       = 6,
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [15:0]                                       scroll_x,
  input  logic [15:0]                                       scroll_y,
  input  logic [3*CH_BITS-1:0]                              border_rgb,
  output logic [XB+YB-1:0]                                  mem_addr,
  input  logic [3*(2**(TW_LOG2+TH_LOG2))*CH_BITS-1:0]       mem_rdata,
  output logic [CH_BITS-1:0]                                red,
  output logic [CH_BITS-1:0]                                green,
  output logic [CH_BITS-1:0]                                blue,
  output logic                                              sync_h,
  output logic                                              sync_v,
  output logic                                              disp_en,
  output logic                                              frame_start
);

  localparam int LW  = TW_LOG2 + TH_LOG2;
  localparam int TP  = 2 ** LW;
  localparam int FLD = TP * CH_BITS;
  localparam int W   = TILES_X << TW_LOG2;
  localparam int HPX = TILES_Y << TH_LOG2;
  localparam int HW  = $clog2(H_ACT + H_FP + H_SYNC + H_BP);
  localparam int VW  = $clog2(V_ACT + V_FP + V_SYNC + V_BP);

  logic [HW-1:0] cnt_h;
  logic [VW-1:0] cnt_v;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic          frame_first;
  logic          frame_last;

  scanout_timing #(
    .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP),
    .HW    (HW),     .VW   (VW)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .cnt_h       (cnt_h),
    .cnt_v       (cnt_v),
    .active      (active),
    .hs_on       (hs_on),
    .vs_on       (vs_on),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  logic [15:0] scx;
  logic [15:0] scy;

  // Out-of-range scroll would break the single-subtract wrap below, so it loads as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scx <= '0;
      scy <= '0;
    end else if (frame_last) begin
      scx <= (32'(scroll_x) >= W)   ? '0 : scroll_x;
      scy <= (32'(scroll_y) >= HPX) ? '0 : scroll_y;
    end
  end

  logic [31:0]        sum_x;
  logic [31:0]        sum_y;
  logic [31:0]        sx;
  logic [31:0]        sy;
  logic [XB-1:0]      tile_x;
  logic [YB-1:0]      tile_y;
  logic [TW_LOG2-1:0] off_x;
  logic [TH_LOG2-1:0] off_y;
  logic               in_mem;

  assign sum_x  = 32'(cnt_h) + 32'(scx);
  assign sum_y  = 32'(cnt_v) + 32'(scy);
  assign sx     = (sum_x >= W)   ? sum_x - W   : sum_x;
  assign sy     = (sum_y >= HPX) ? sum_y - HPX : sum_y;
  assign tile_x = sx[TW_LOG2 +: XB];
  assign tile_y = sy[TH_LOG2 +: YB];
  assign off_x  = sx[TW_LOG2-1:0];
  assign off_y  = sy[TH_LOG2-1:0];
  // The tile-area test uses unscrolled screen position: scrolling moves content, not the border.
  assign in_mem = active && (32'(cnt_h) < W) && (32'(cnt_v) < HPX);

  // Bit 0 of each delay line lines up with S1, bit 1 with S2, bit 2 with the pins.
  logic [2:0] de_d;
  logic [2:0] hs_d;
  logic [2:0] vs_d;
  logic [2:0] fs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
      fs_d <= '0;
    end else begin
      de_d <= {de_d[1:0], active};
      hs_d <= {hs_d[1:0], hs_on};
      vs_d <= {vs_d[1:0], vs_on};
      fs_d <= {fs_d[1:0], frame_first};
    end
  end

  logic [TW_LOG2-1:0] s1_off_x;
  logic [TH_LOG2-1:0] s1_off_y;
  logic               s1_in_mem;
  logic [TW_LOG2-1:0] s2_off_x;
  logic [TH_LOG2-1:0] s2_off_y;
  logic               s2_in_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      s1_off_x  <= '0;
      s1_off_y  <= '0;
      s1_in_mem <= 1'b0;
      s2_off_x  <= '0;
      s2_off_y  <= '0;
      s2_in_mem <= 1'b0;
    end else begin
      mem_addr  <= {tile_x, tile_y};
      s1_off_x  <= off_x;
      s1_off_y  <= off_y;
      s1_in_mem <= in_mem;
      s2_off_x  <= s1_off_x;
      s2_off_y  <= s1_off_y;
      s2_in_mem <= s1_in_mem;
    end
  end

  logic [LW-1:0]        loc;
  logic [3*CH_BITS-1:0] pix_rgb;

  // mem_rdata packs {blues, greens, reds}; pix_rgb is ordered {r, g, b}.
  always_comb begin
    loc     = LW'(pix_index(32'(s2_off_x), 32'(s2_off_y), TW_LOG2));
    pix_rgb = '0;
    if (de_d[1] && s2_in_mem) begin
      pix_rgb = {mem_rdata[32'(loc)*CH_BITS +: CH_BITS],
                 mem_rdata[FLD + 32'(loc)*CH_BITS +: CH_BITS],
                 mem_rdata[2*FLD + 32'(loc)*CH_BITS +: CH_BITS]};
    end
`ifdef TILE_SCANOUT_BORDER_EN
    else if (de_d[1]) begin
      pix_rgb = border_rgb;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      {red, green, blue} <= pix_rgb;
    end
  end

  assign sync_h      = sync_level(hs_d[2], SYNC_POL != 0);
  assign sync_v      = sync_level(vs_d[2], SYNC_POL != 0);
  assign disp_en     = de_d[2];
  assign frame_start = fs_d[2];

  logic unused_bits;
`ifdef TILE_SCANOUT_BORDER_EN
  assign unused_bits = &{1'b0, sx[31:TW_LOG2+XB], sy[31:TH_LOG2+YB]};
`else
  assign unused_bits = &{1'b0, sx[31:TW_LOG2+XB], sy[31:TH_LOG2+YB], border_rgb};
`endif

endmodule

// File: tb/tb_tile_scanout.sv
// Scoreboard bench for tile_scanout on a reduced 4x2-tile geometry (W=32, H=16, 56x28 raster).
`timescale 1ns/1ps
module tb_tile_scanout;

  localparam int CH = 4;
  localparam int XB = 2;
  localparam int YB = 1;
  localparam int TP = 64;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VS = 3, VB = 3, VT = VA + VF + VS + VB;
  localparam int W  = 32;
  localparam int HH = 16;
  localparam logic [11:0] BORDER = 12'hABC;
`ifdef TILE_SCANOUT_BORDER_EN
  localparam logic [11:0] BEXP = BORDER;
`else
  localparam logic [11:0] BEXP = 12'h000;
`endif
  // {rgb, sync_h, sync_v, disp_en, frame_start} with active-low sync idle high
  localparam logic [15:0] RST_VAL = 16'h000C;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [15:0]          scroll_x = '0;
  logic [15:0]          scroll_y = '0;
  logic [11:0]          border_rgb = BORDER;
  logic [XB+YB-1:0]     mem_addr;
  logic [3*TP*CH-1:0]   mem_rdata = '0;
  logic [CH-1:0]        red, green, blue;
  logic                 sync_h, sync_v, disp_en, frame_start;

  always #5 clk = ~clk;

  tile_scanout #(
    .CH_BITS (CH), .TW_LOG2 (3), .TH_LOG2 (3), .TILES_X (4), .TILES_Y (2),
    .XB (XB), .YB (YB),
    .H_ACT (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACT (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (0)
  ) dut (
    .clk (clk), .rst (rst), .scroll_x (scroll_x), .scroll_y (scroll_y),
    .border_rgb (border_rgb), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .red (red), .green (green), .blue (blue), .sync_h (sync_h), .sync_v (sync_v),
    .disp_en (disp_en), .frame_start (frame_start)
  );

  // Tile RAM: red = loc mod 16, green = tile_x*4 + tile_y, blue = loc / 16.
  function automatic logic [3*TP*CH-1:0] ram_word(input logic [XB+YB-1:0] a);
    logic [3*TP*CH-1:0] w;
    int tx;
    int ty;
    w  = '0;
    tx = int'(a[XB+YB-1:YB]);
    ty = int'(a[YB-1:0]);
    for (int p = 0; p < TP; p++) begin
      w[p*CH +: CH]           = 4'(p % 16);
      w[TP*CH + p*CH +: CH]   = 4'(tx * 4 + ty);
      w[2*TP*CH + p*CH +: CH] = 4'(p / 16);
    end
    return w;
  endfunction

  always @(posedge clk) mem_rdata <= ram_word(mem_addr);

  function automatic logic [15:0] model(input int h, input int v, input int scx, input int scy);
    logic act, inm, sh, sv;
    int sx, sy, loc, tx, ty;
    logic [11:0] rgb;
    act = (h < HA) && (v < VA);
    inm = act && (h < W) && (v < HH);
    sh  = (h >= HA + HF) && (h < HA + HF + HS);
    sv  = (v >= VA + VF) && (v < VA + VF + VS);
    sx  = h + scx;
    if (sx >= W) sx -= W;
    sy  = v + scy;
    if (sy >= HH) sy -= HH;
    tx  = sx / 8;
    ty  = sy / 8;
    loc = (sy % 8) * 8 + (sx % 8);
    rgb = 12'h000;
    if (inm) rgb = {4'(loc % 16), 4'(tx * 4 + ty), 4'(loc / 16)};
    else if (act) rgb = BEXP;
    return {rgb, !sh, !sv, act, (h == 0) && (v == 0)};
  endfunction

  typedef struct { int frame; int h; int v; logic [15:0] val; } exp_t;
  typedef struct { int frame; int h; int v; logic [11:0] rgb; } dir_t;
  exp_t q[$];
  dir_t dq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int mh = 0, mv = 0, mf = 0, mscx = 0, mscy = 0;

  // Model + monitor: expectations enter at the counter state and leave three clocks later.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] got;
    got = {red, green, blue, sync_h, sync_v, disp_en, frame_start};
    if (rst) begin
      n_cmp++;
      if (got !== RST_VAL || mem_addr !== '0) begin
        n_bad++;
        $display("FAIL reset_state: got %h addr %h, expected %h addr 0", got, mem_addr, RST_VAL);
      end
      q.delete();
      for (int i = 0; i < 3; i++) begin
        e = '{-1, -1, -1, RST_VAL};
        q.push_back(e);
      end
      mh = 0; mv = 0; mf = 0; mscx = 0; mscy = 0;
    end else begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: got %h, expected an entry", got);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (got !== e.val) begin
          n_bad++;
          $display("FAIL pixel f%0d h%0d v%0d: got %h expected %h", e.frame, e.h, e.v, got, e.val);
        end
        if (dq.size() > 0 && dq[0].frame == e.frame && dq[0].h == e.h && dq[0].v == e.v) begin
          n_cmp++;
          if (got[15:4] !== dq[0].rgb) begin
            n_bad++;
            $display("FAIL directed f%0d h%0d v%0d: got rgb %h expected %h",
                     e.frame, e.h, e.v, got[15:4], dq[0].rgb);
          end
          void'(dq.pop_front());
        end
      end
      e = '{mf, mh, mv, model(mh, mv, mscx, mscy)};
      q.push_back(e);
      if (mh == HT - 1 && mv == VT - 1) begin
        mscx = (scroll_x >= W)  ? 0 : int'(scroll_x);
        mscy = (scroll_y >= HH) ? 0 : int'(scroll_y);
      end
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; mf++; end
        else mv++;
      end else begin
        mh++;
      end
    end
  end

  task automatic add(input int f, input int h, input int v, input logic [11:0] rgb);
    dir_t d;
    d = '{f, h, v, rgb};
    dq.push_back(d);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // frame 0: no scroll
    add(0, 0, 0, 12'h000);   add(0, 5, 0, 12'h500);   add(0, 32, 0, BEXP);
    add(0, 3, 1, 12'hB00);   add(0, 9, 1, 12'h940);   add(0, 31, 15, 12'hFD3);
    add(0, 0, 16, BEXP);     add(0, 39, 19, BEXP);
    // frame 1: scroll 4/8
    add(1, 0, 0, 12'h410);   add(1, 28, 0, 12'h010);  add(1, 0, 8, 12'h400);
    add(1, 27, 15, 12'hFC3);
    // frame 2: scroll W-1/0
    add(2, 0, 0, 12'h7C0);   add(2, 1, 0, 12'h000);   add(2, 1, 8, 12'h010);
    // frame 3: out-of-range scroll loads as 0
    add(3, 1, 0, 12'h100);   add(3, 17, 3, 12'h981);  add(3, 0, 9, 12'h810);

    cycles(3);
    rst = 1'b0;
    cycles(200);
    scroll_x = 16'd4;  scroll_y = 16'd8;
    cycles(HT * VT);
    scroll_x = 16'd31; scroll_y = 16'd0;
    cycles(HT * VT);
    scroll_x = 16'd40; scroll_y = 16'd20;
    cycles(HT * VT);
    cycles(700);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({red, green, blue, sync_h, sync_v, disp_en, frame_start} !== RST_VAL || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h addr %h, expected %h addr 0",
               {red, green, blue, sync_h, sync_v, disp_en, frame_start}, mem_addr, RST_VAL);
    end
    cycles(3);
    rst = 1'b0;
    cycles(HT * VT + 50);
    n_cmp++;
    if (dq.size() != 0) begin
      n_bad++;
      $display("FAIL directed_unmatched: %0d left, expected 0", dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
